// File: rtl/bcd_disp_pkg.sv
// Shared constants and the BCD-to-7-segment decode for the display scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high here;
// panel polarity is applied by the top.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Standard digit shapes for 0..9; codes 10..15 show a dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational single-digit decoder, active-high segments.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner. Digits are captured into a shadow
// copy once per frame so the counter bank can update freely without tearing.
// Each digit is selected for SCAN_DIV clocks; outputs are registered.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    // Unlit / deselected levels for the chosen panel polarity
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]            ps;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   shadow;
    logic [DIGITS-1:0]        shadow_dp;
    logic [DIGITS-1:0][6:0]   dec_seg;
    logic [DIGITS-1:0]        blank;
    logic [DIGITS-1:0]        sel_oh;
    logic                     tick;
    logic                     wrap;

    assign tick = (ps == PS_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Prescaler and digit index; idx advances once every SCAN_DIV clocks
    always_ff @(posedge clk) begin
        if (!reset) begin
            ps  <= '0;
            idx <= '0;
        end else begin
            ps <= tick ? '0 : ps + PW'(1);
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    // Frame snapshot: capture digits and dps only at frame wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow      <= '0;
            shadow_dp   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (wrap) begin
                shadow    <= digits_in;
                shadow_dp <= dp_in;
            end
        end
    end

    // One decoder per digit, muxed by idx below
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .bcd (shadow[g]),
            .seg (dec_seg[g])
        );
    end

    // Leading-zero mask: zero, dp-clear digits above the highest nonzero
    // digit are blanked; digit 0 always shows
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (shadow[i] != 4'd0)
                    seen = 1'b1;
                if (!seen && (shadow[i] == 4'd0) && !shadow_dp[i])
                    blank[i] = 1'b1;
            end
        end
`endif
    end

    // One-hot select for the current slot, active-high
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < DIGITS; i++)
            sel_oh[i] = (idx == IW'(i));
    end

    // Registered panel drive: reflects idx and shadow one clock later
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else if (blank[idx]) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= dec_seg[idx] ^ {7{SEG_ACTIVE_LOW}};
            dp  <= shadow_dp[idx] ^ SEG_ACTIVE_LOW;
            an  <= sel_oh ^ {DIGITS{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner (DIGITS=4, SCAN_DIV=4, active-low panel).
// A cycle-count model predicts every output each clock; directed literal
// checks pin the model. Honors LEADING_ZERO_BLANK_EN like the design.
module tb_bcd_display_scanner;

    localparam int D = 4;
    localparam int S = 4;

    logic            clk;
    logic            reset;
    logic [4*D-1:0]  digits_in;
    logic [D-1:0]    dp_in;
    logic [6:0]      seg;
    logic            dp;
    logic [D-1:0]    an;
    logic            frame_start;

    int checks = 0;
    int errors = 0;

    bcd_display_scanner #(
        .DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active-high shapes 0..9, then dash for 10..15
    logic [6:0] shape [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model: n = clocks since reset release. Slot shown after clock n is
    // ((n-1)/S)%D; a new snapshot is taken on every clock n that is a
    // multiple of S*D and shows from the following clock.
    logic [6:0]   exp_seg;
    logic         exp_dp;
    logic [D-1:0] exp_an;
    logic         exp_fs;
    logic         mvalid = 1'b0;

    initial begin
        int n;
        logic [3:0] msh [D];
        logic       mdp [D];
        n = 0;
        for (int i = 0; i < D; i++) begin msh[i] = 4'd0; mdp[i] = 1'b0; end
        forever begin
            @(posedge clk);
            if (!reset) begin
                n = 0;
                for (int i = 0; i < D; i++) begin msh[i] = 4'd0; mdp[i] = 1'b0; end
                exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = '1; exp_fs = 1'b0;
            end else begin
                int slot, msnz;
                logic blk;
                logic [D-1:0] one;
                n = n + 1;
                slot = ((n - 1) / S) % D;
                msnz = -1;
                for (int i = 0; i < D; i++) if (msh[i] != 4'd0) msnz = i;
                blk = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                if (slot != 0 && slot > msnz && msh[slot] == 4'd0 && !mdp[slot]) blk = 1'b1;
`endif
                one = 1;
                if (blk) begin
                    exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = '1;
                end else begin
                    exp_seg = ~shape[msh[slot]];
                    exp_dp  = ~mdp[slot];
                    exp_an  = ~(one << slot);
                end
                exp_fs = (n % (S * D) == 0);
                if (n % (S * D) == 0)
                    for (int i = 0; i < D; i++) begin
                        msh[i] = digits_in[4*i +: 4];
                        mdp[i] = dp_in[i];
                    end
            end
            mvalid = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("model.seg", {25'd0, seg}, {25'd0, exp_seg});
                chk("model.dp", {31'd0, dp}, {31'd0, exp_dp});
                chk("model.an", {28'd0, an}, {28'd0, exp_an});
                chk("model.frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_fs(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) got = 1'b1;
        end
        chk(name, {31'd0, got}, 32'd1);
    endtask

    task automatic wait_an(input string name, input logic [D-1:0] v);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (an === v) got = 1'b1;
        end
        chk(name, {31'd0, got}, 32'd1);
    endtask

    task automatic lit(input string name, input logic [D-1:0] ean, input logic [6:0] eseg);
        chk({name, ".an"}, {28'd0, an}, {28'd0, ean});
        chk({name, ".seg"}, {25'd0, seg}, {25'd0, eseg});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        digits_in = '0;
        dp_in = '0;

        // 1. Reset held three clocks
        for (int i = 0; i < 3; i++) begin
            step(1);
            lit("reset", 4'b1111, 7'h7F);
            chk("reset.dp", {31'd0, dp}, 32'd1);
            chk("reset.frame_start", {31'd0, frame_start}, 32'd0);
        end

        // 2. Scan 1234
        reset = 1'b1;
        digits_in = 16'h1234;
        wait_fs("t2.wait_fs");
        step(1); lit("t2.d0", 4'b1110, 7'h19);
        step(3); lit("t2.d0_last", 4'b1110, 7'h19);
        step(1); lit("t2.d1", 4'b1101, 7'h30);
        step(4); lit("t2.d2", 4'b1011, 7'h24);

        // 3. Change inputs mid-frame: no effect until next snapshot
        digits_in = 16'h5678;
        step(4); lit("t3.d3_old", 4'b0111, 7'h79);
        wait_fs("t3.wait_fs");
        step(1); lit("t3.d0_new", 4'b1110, 7'h00);
        step(4); lit("t3.d1_new", 4'b1101, 7'h78);

        // 4. Dash with decimal point
        digits_in = 16'h00A0;
        dp_in = 4'b0010;
        wait_fs("t4.wait_fs");
        step(1); lit("t4.d0", 4'b1110, 7'h40);
        step(4); lit("t4.d1", 4'b1101, 7'h3F);
        chk("t4.d1.dp", {31'd0, dp}, 32'd0);

        // 5. Reset pulse mid-scan
        dp_in = '0;
        wait_an("t5.wait_an", 4'b1011);
        reset = 1'b0;
        step(1); lit("t5.in_reset", 4'b1111, 7'h7F);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1); lit("t5.d0_hold", 4'b1110, 7'h40);
        end
        step(1); lit("t5.d1", 4'b1101, 7'h40);

        // 6. Leading zeros
        digits_in = 16'h0050;
        wait_fs("t6.wait_fs");
        step(1); lit("t6.d0", 4'b1110, 7'h40);
        step(4); lit("t6.d1", 4'b1101, 7'h12);
`ifdef LEADING_ZERO_BLANK_EN
        step(4); lit("t6.d2", 4'b1111, 7'h7F);
        step(4); lit("t6.d3", 4'b1111, 7'h7F);
`else
        step(4); lit("t6.d2", 4'b1011, 7'h40);
        step(4); lit("t6.d3", 4'b0111, 7'h40);
`endif
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
